// File: rtl/input_debounce_bank_if.sv
// Change-event stream from the debounce bank: valid/ready handshake carrying
// a state snapshot, accumulated changed bits and an overrun flag.
interface input_debounce_bank_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_data;
  logic [7:0] ev_changed;
  logic       ev_overrun;

  modport master (
    output ev_valid,
    output ev_data,
    output ev_changed,
    output ev_overrun,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_data,
    input  ev_changed,
    input  ev_overrun,
    output ev_ready
  );
endinterface

// File: rtl/input_debounce_bank.sv
// Eight-channel input debouncer: 2-flop synchronizers, shared tick prescaler,
// per-bit mismatch counters, edge pulses and a coalescing change-event stream.
module input_debounce_bank #(
  parameter int TICK_DIV       = 12000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   pins,
  output logic [7:0]                   state,
  output logic [7:0]                   rise,
  output logic [7:0]                   fall,
  input_debounce_bank_if.master        ev
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_TICKS - 1);

  logic [7:0]    meta_reg;
  logic [7:0]    sync_reg;
  logic [PW-1:0] presc_reg;
  logic          tick;
  logic [7:0]    state_reg;
  logic [7:0]    state_next;
  logic [7:0]    state_d_reg;
  logic [7:0]    rise_reg;
  logic [7:0]    fall_reg;
  logic          ev_valid_reg;
  logic [7:0]    ev_data_reg;
  logic [7:0]    ev_changed_reg;
  logic          ev_overrun_reg;
  logic [7:0]    changed;
  logic          change;
  logic          xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= pins;
      sync_reg <= meta_reg;
    end
  end

  // Free-running prescaler; never stalls, whatever the event stream does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  assign tick = (presc_reg == PRESC_LAST);

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    logic [CW-1:0] cnt_reg;
    logic          mismatch;
    logic          accept;

    assign mismatch       = sync_reg[gi] ^ state_reg[gi];
    assign accept         = mismatch && tick && (cnt_reg == CNT_LAST);
    assign state_next[gi] = accept ? sync_reg[gi] : state_reg[gi];

    // Any matching cycle, even between ticks, restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (!mismatch || accept) begin
        cnt_reg <= '0;
      end else if (tick) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= '0;
      state_d_reg <= '0;
      rise_reg    <= '0;
      fall_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      state_d_reg <= state_reg;
      rise_reg    <= state_reg & ~state_d_reg;
      fall_reg    <= ~state_reg & state_d_reg;
    end
  end

  assign changed = state_next ^ state_reg;
  assign change  = |changed;
  assign xfer    = ev_valid_reg & ev.ev_ready;

  // A change that lands while an event is still held merges into it and flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid_reg   <= 1'b0;
      ev_data_reg    <= '0;
      ev_changed_reg <= '0;
      ev_overrun_reg <= 1'b0;
    end else if (change) begin
      ev_valid_reg <= 1'b1;
      ev_data_reg  <= state_next;
      if (!ev_valid_reg || xfer) begin
        ev_changed_reg <= changed;
        ev_overrun_reg <= 1'b0;
      end else begin
        ev_changed_reg <= ev_changed_reg | changed;
        ev_overrun_reg <= 1'b1;
      end
    end else if (xfer) begin
      ev_valid_reg   <= 1'b0;
      ev_changed_reg <= '0;
      ev_overrun_reg <= 1'b0;
    end
  end

  assign state         = state_reg;
  assign rise          = rise_reg;
  assign fall          = fall_reg;
  assign ev.ev_valid   = ev_valid_reg;
  assign ev.ev_data    = ev_data_reg;
  assign ev.ev_changed = ev_changed_reg;
  assign ev.ev_overrun = ev_overrun_reg;

endmodule

// File: tb/tb_input_debounce_bank.sv
// Bench for input_debounce_bank: one instance at TICK_DIV=4/DEBOUNCE_TICKS=3,
// one at 1/1, checked every cycle against an interval-counting model.
module tb_input_debounce_bank;
  localparam int TD_A = 4;
  localparam int DT_A = 3;
  localparam int TD_B = 1;
  localparam int DT_B = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pins_a = 8'h00;
  logic [7:0] pins_b = 8'h00;
  logic       ready_a = 1'b0;
  logic       ready_b = 1'b0;
  logic [7:0] state_a, rise_a, fall_a;
  logic [7:0] state_b, rise_b, fall_b;

  always #5 clk = ~clk;

  input_debounce_bank_if ev_a();
  input_debounce_bank_if ev_b();
  assign ev_a.ev_ready = ready_a;
  assign ev_b.ev_ready = ready_b;

  input_debounce_bank #(.TICK_DIV(TD_A), .DEBOUNCE_TICKS(DT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .pins(pins_a),
    .state(state_a), .rise(rise_a), .fall(fall_a), .ev(ev_a)
  );

  input_debounce_bank #(.TICK_DIV(TD_B), .DEBOUNCE_TICKS(DT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .pins(pins_b),
    .state(state_b), .rise(rise_b), .fall(fall_b), .ev(ev_b)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
  endtask

  // Model: a bit flips once DEBOUNCE_TICKS ticks fall inside an unbroken mismatch
  // interval, ticks counted arithmetically from the cycle index since reset.
  logic [7:0] s1_m[2], sync_m[2], st_m[2], rise_m[2], fall_m[2];
  logic [7:0] prise_m[2], pfall_m[2], dat_m[2], chg_m[2];
  logic       val_m[2], ovr_m[2];
  int         cyc_m[2];
  int         lm_m[2][8];

  function automatic int ticks_upto(input int x, input int td);
    return (x + 1) / td;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      s1_m[i] = '0; sync_m[i] = '0; st_m[i] = '0; rise_m[i] = '0; fall_m[i] = '0;
      prise_m[i] = '0; pfall_m[i] = '0; dat_m[i] = '0; chg_m[i] = '0;
      val_m[i] = 1'b0; ovr_m[i] = 1'b0; cyc_m[i] = 0;
      for (int b = 0; b < 8; b++) lm_m[i][b] = -1;
    end
  endtask

  task automatic model_step();
    logic [7:0] pin_v, new_st, chg;
    logic       rdy, tk;
    int         td, dt, c;
    for (int i = 0; i < 2; i++) begin
      pin_v = (i == 0) ? pins_a : pins_b;
      rdy   = (i == 0) ? ready_a : ready_b;
      td    = (i == 0) ? TD_A : TD_B;
      dt    = (i == 0) ? DT_A : DT_B;
      c     = cyc_m[i];
      tk    = (c % td) == td - 1;
      new_st = st_m[i];
      for (int b = 0; b < 8; b++) begin
        if (sync_m[i][b] == st_m[i][b]) begin
          lm_m[i][b] = c;
        end else if (tk && (ticks_upto(c, td) - ticks_upto(lm_m[i][b], td) == dt)) begin
          new_st[b] = sync_m[i][b];
          lm_m[i][b] = c;
        end
      end
      rise_m[i]  = prise_m[i];
      fall_m[i]  = pfall_m[i];
      prise_m[i] = new_st & ~st_m[i];
      pfall_m[i] = ~new_st & st_m[i];
      chg = new_st ^ st_m[i];
      if (chg != 8'h00) begin
        dat_m[i] = new_st;
        if (!val_m[i] || rdy) begin
          chg_m[i] = chg;
          ovr_m[i] = 1'b0;
        end else begin
          chg_m[i] = chg_m[i] | chg;
          ovr_m[i] = 1'b1;
        end
        val_m[i] = 1'b1;
      end else if (val_m[i] && rdy) begin
        val_m[i] = 1'b0;
        chg_m[i] = '0;
        ovr_m[i] = 1'b0;
      end
      sync_m[i] = s1_m[i];
      s1_m[i]   = pin_v;
      st_m[i]   = new_st;
      cyc_m[i]  = c + 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("a.state", state_a, st_m[0]);
      chk("a.rise", rise_a, rise_m[0]);
      chk("a.fall", fall_a, fall_m[0]);
      chk("a.ev_valid", 8'(ev_a.ev_valid), 8'(val_m[0]));
      chk("a.ev_data", ev_a.ev_data, dat_m[0]);
      chk("a.ev_changed", ev_a.ev_changed, chg_m[0]);
      chk("a.ev_overrun", 8'(ev_a.ev_overrun), 8'(ovr_m[0]));
      chk("b.state", state_b, st_m[1]);
      chk("b.rise", rise_b, rise_m[1]);
      chk("b.fall", fall_b, fall_m[1]);
      chk("b.ev_valid", 8'(ev_b.ev_valid), 8'(val_m[1]));
      chk("b.ev_data", ev_b.ev_data, dat_m[1]);
      chk("b.ev_changed", ev_b.ev_changed, chg_m[1]);
      chk("b.ev_overrun", 8'(ev_b.ev_overrun), 8'(ovr_m[1]));
    end
  end

  int rise2_cnt;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rise_a[2]) rise2_cnt++;
    end
  endtask

  logic [7:0] vec_b[12] = '{8'h5A, 8'h5A, 8'hA5, 8'h00, 8'hFF, 8'hFF,
                            8'h0F, 8'hF0, 8'hF0, 8'h81, 8'h00, 8'h00};

  initial begin
    rise2_cnt = 0;
    step(3);
    chk("lit.reset.state", state_a, 8'h00);
    chk("lit.reset.valid", 8'(ev_a.ev_valid), 8'h00);

    // Epoch 1: clean press on a, single-cycle-latency behaviour on b.
    rst_n = 1'b1; pins_a = 8'h01; pins_b = 8'h3C; ready_b = 1'b1;
    step(2);  chk("lit.b.state_hold", state_b, 8'h00);
    step(1);  chk("lit.b.state_follow", state_b, 8'h3C);
    step(1);  chk("lit.b.rise", rise_b, 8'h3C);
    pins_b = 8'h0C;
    step(3);  chk("lit.b.state_rel", state_b, 8'h0C);
    step(1);  chk("lit.b.fall", fall_b, 8'h30);
              chk("lit.b.no_rise", rise_b, 8'h00);
    step(3);  chk("lit.a.before_3rd_tick", state_a, 8'h00);
    step(1);  chk("lit.a.press_state", state_a, 8'h01);
              chk("lit.a.press_valid", 8'(ev_a.ev_valid), 8'h01);
              chk("lit.a.press_data", ev_a.ev_data, 8'h01);
              chk("lit.a.press_changed", ev_a.ev_changed, 8'h01);
              chk("lit.a.rise_not_yet", rise_a, 8'h00);
    step(1);  chk("lit.a.rise", rise_a, 8'h01);
    step(1);  chk("lit.a.rise_one_cycle", rise_a, 8'h00);

    // Overrun on a while b runs a directed vector table.
    pins_a = 8'h81;
    for (int k = 0; k < 12; k++) begin
      pins_b = vec_b[k];
      ready_b = k[0];
      step(2);
    end
    chk("lit.ovr.data", ev_a.ev_data, 8'h81);
    chk("lit.ovr.changed", ev_a.ev_changed, 8'h81);
    chk("lit.ovr.overrun", 8'(ev_a.ev_overrun), 8'h01);
    ready_a = 1'b1;
    step(1);
    ready_a = 1'b0;
    chk("lit.xfer.valid", 8'(ev_a.ev_valid), 8'h00);
    chk("lit.xfer.changed", ev_a.ev_changed, 8'h00);
    chk("lit.xfer.overrun", 8'(ev_a.ev_overrun), 8'h00);
    chk("lit.xfer.data_kept", ev_a.ev_data, 8'h81);

    // Epoch 2: transfer coinciding with a new change.
    rst_n = 1'b0; pins_a = 8'h00; pins_b = 8'h00; ready_b = 1'b1;
    step(2);
    rst_n = 1'b1; pins_a = 8'h01;
    step(12); chk("lit.sim.pending", ev_a.ev_data, 8'h01);
    pins_a = 8'h09;
    step(11); chk("lit.sim.before", state_a, 8'h01);
    ready_a = 1'b1;
    step(1);
    ready_a = 1'b0;
    chk("lit.sim.state", state_a, 8'h09);
    chk("lit.sim.valid", 8'(ev_a.ev_valid), 8'h01);
    chk("lit.sim.data", ev_a.ev_data, 8'h09);
    chk("lit.sim.changed", ev_a.ev_changed, 8'h08);
    chk("lit.sim.overrun", 8'(ev_a.ev_overrun), 8'h00);

    // Bounce on pin 2: two ticks high, one-cycle glitch, then steady.
    ready_a = 1'b1; pins_a = 8'h0D; rise2_cnt = 0;
    step(8);  pins_a = 8'h09;
    step(1);  pins_a = 8'h0D;
    step(10); chk("lit.bounce.hold", state_a, 8'h09);
    step(1);  chk("lit.bounce.accept", state_a, 8'h0D);
    step(4);  chk("lit.bounce.one_rise", 8'(rise2_cnt), 8'h01);

    // Mid-cycle asynchronous reset with everything high and an event pending.
    ready_a = 1'b0; ready_b = 1'b0; pins_a = 8'hFF; pins_b = 8'hFF;
    step(30);
    chk("lit.pre_rst.state", state_a, 8'hFF);
    chk("lit.pre_rst.valid", 8'(ev_a.ev_valid), 8'h01);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit.arst.state", state_a, 8'h00);
    chk("lit.arst.rise", rise_a, 8'h00);
    chk("lit.arst.fall", fall_a, 8'h00);
    chk("lit.arst.valid", 8'(ev_a.ev_valid), 8'h00);
    chk("lit.arst.data", ev_a.ev_data, 8'h00);
    chk("lit.arst.changed", ev_a.ev_changed, 8'h00);
    chk("lit.arst.overrun", 8'(ev_a.ev_overrun), 8'h00);
    chk("lit.arst.b_state", state_b, 8'h00);
    step(3);
    rst_n = 1'b1;
    step(2);  chk("lit.held.b_hold", state_b, 8'h00);
    step(1);  chk("lit.held.b_state", state_b, 8'hFF);
              chk("lit.held.b_valid", 8'(ev_b.ev_valid), 8'h01);
              chk("lit.held.b_data", ev_b.ev_data, 8'hFF);
    step(1);  chk("lit.held.b_rise", rise_b, 8'hFF);
    step(8);  chk("lit.held.a_state", state_a, 8'hFF);
              chk("lit.held.a_changed", ev_a.ev_changed, 8'hFF);
    step(1);  chk("lit.held.a_rise", rise_a, 8'hFF);
    step(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/input_debounce_bank.md
INPUT_DEBOUNCE_BANK -- requirements
Module: input_debounce_bank

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12000, clk cycles per debounce sample tick (1 ms at 12 MHz); legal range >= 1.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 10, consecutive mismatching ticks required to accept a new level; legal range >= 1.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pins  input  8  raw asynchronous active-high inputs (buttons/switches).
REQ-006 SHALL have port state  output  8  debounced level per bit.
REQ-007 SHALL have port rise  output  8  one-cycle pulse per bit on debounced 0->1.
REQ-008 SHALL have port fall  output  8  one-cycle pulse per bit on debounced 1->0.
REQ-009 SHALL have port ev_valid  output  1  change event pending.
REQ-010 SHALL have port ev_ready  input  1  consumer accepts event.
REQ-011 SHALL have port ev_data  output  8  debounced state snapshot at latest change.
REQ-012 SHALL have port ev_changed  output  8  OR of all bits changed since last accept.
REQ-013 SHALL have port ev_overrun  output  1  change occurred while event already pending.

Function
REQ-014 SHALL pass each pins bit through a 2-flop synchronizer; only the second-stage value (sync) feeds later logic.
REQ-015 SHALL run one shared prescaler counting 0..TICK_DIV-1, wrapping to 0, asserting internal tick for exactly the one cycle where count == TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-016 SHALL keep per-bit counter of width ceil(log2(DEBOUNCE_TICKS)) (min 1); any cycle with sync == state clears it to 0.
REQ-017 SHALL, on a tick with sync != state: if counter == DEBOUNCE_TICKS-1 then state <= sync and counter <= 0, else counter increments.
REQ-018 SHALL therefore accept a change on the DEBOUNCE_TICKS-th consecutive mismatching tick; one matching cycle anywhere in between restarts the count.
REQ-019 SHALL register rise/fall so they assert in the cycle after state updates, high exactly one cycle, never both for one bit.
REQ-020 SHALL detect a change event when any state bit changes; multiple bits changing in one cycle form one event.
REQ-021 SHALL, on change event with ev_valid=0: ev_valid <= 1, ev_data <= new state, ev_changed <= changed bits, ev_overrun <= 0.
REQ-022 SHALL complete a transfer on a clock edge where ev_valid && ev_ready; ev_ready while ev_valid=0 has no effect.
REQ-023 SHALL hold ev_valid, ev_data, ev_changed, ev_overrun stable while ev_valid && !ev_ready and no new change occurs.
REQ-024 SHALL, on change event while ev_valid && !ev_ready: ev_data <= new state, ev_changed <= ev_changed | changed bits, ev_overrun <= 1, ev_valid stays 1.
REQ-025 SHALL, on transfer with no simultaneous change: ev_valid <= 0, ev_changed <= 0, ev_overrun <= 0; ev_data retains value.
REQ-026 SHALL, on transfer coinciding with a change event: load new event per REQ-021 (ev_changed = new changed bits only, ev_overrun 0), ev_valid stays 1.
REQ-027 SHALL keep all counters free-running under wrap; prescaler never stalls, including while ev_valid is stuck high.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force synchronizer flops, prescaler, per-bit counters, state, rise, fall, ev_valid, ev_data, ev_changed, ev_overrun to 0.
REQ-029 SHALL resume with prescaler at 0 on first edge after rst_n deasserts; reset mid-debounce discards partial counts; a pin held high through reset yields a normal rise and event after debounce.

Verification (TICK_DIV=4, DEBOUNCE_TICKS=3 unless noted)
REQ-030 Reset: rst_n=0 asynchronously mid-cycle with state=8'hFF, ev_valid=1 -> all outputs 0 immediately, before next clk edge.
REQ-031 Clean press: pins[0] 0->1 held -> state[0]=1 on 3rd tick after sync sees 1; rise[0] one cycle later for 1 cycle; ev_valid=1, ev_data=8'h01, ev_changed=8'h01.
REQ-032 Bounce: pins[2] high 2 ticks, low 1 cycle, high steady -> no change until 3 full ticks after last glitch; exactly one rise[2], one event.
REQ-033 Overrun: ev_ready=0, debounce pins[0] then pins[7] high -> ev_data=8'h81, ev_changed=8'h81, ev_overrun=1; assert ev_ready one cycle -> ev_valid=0, ev_changed=0, ev_overrun=0.
REQ-034 Simultaneous: ev_ready high on exact cycle pins[3] change enters state with pending event 8'h01 -> ev_valid stays 1, ev_data=8'h09, ev_changed=8'h08, ev_overrun=0.
REQ-035 Edge params: TICK_DIV=1, DEBOUNCE_TICKS=1 -> state follows sync one cycle later; fall pulses on release; pins held high through reset -> rise and event after deassert.
